fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch front-end for the Simple-CPU. It owns the program counter and drives the 6-bit address into the instruction memory. It captures the 23-bit instruction word that memory returns combinationally and presents it to decode through a valid/ready handshake. It supports branch/jump redirect, a HALT opcode, and a fetched-instruction counter.

Parameters:
ADDR_W, 6, instruction memory address width; PC wraps modulo 2^ADDR_W
CODE_W, 23, instruction word width; the word is {opcode[22:20], reg[19:16], imm[15:0]}
HALT_OP, 3'b111, opcode value that stops fetching
CNT_W, 16, width of fetch_count

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; leaves IDLE
address  output  ADDR_W  instruction memory address; always equals pc
code  input  CODE_W  instruction memory data; combinational from address, valid in the same cycle
instr  output  CODE_W  registered instruction presented to decode
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  decode accepts instr this cycle when instr_valid is 1
redirect_valid  input  1  load pc from redirect_addr and flush instr
redirect_addr  input  ADDR_W  redirect target
pc  output  ADDR_W  current fetch address
halted  output  1  high in the HALTED state
fetch_count  output  CNT_W  number of captures since reset; wraps

Behaviour:
- Reset values (rst sampled high at the clock edge): state=IDLE, pc=0, instr=0, instr_valid=0, halted=0, fetch_count=0. Reset overrides every other input, including when asserted mid-operation.
- address = pc, combinationally, in all states.
- States: IDLE, FETCH, HALTED.
- Slot free: instr_valid==0 OR instr_ready==1.
- Capture: instr<=code, instr_valid<=1, pc<=pc+1 (63 wraps to 0), fetch_count<=fetch_count+1.
- Consume without capture: when the slot is free because of a handshake and no capture occurs, instr_valid<=0.
- IDLE:
  - No capture.
  - start=1 -> FETCH on the next cycle. The first capture happens in the first FETCH cycle.
  - redirect_valid=1 in IDLE updates pc only and does not leave IDLE.
- FETCH, evaluated in priority order each cycle:
  1. redirect_valid=1: pc<=redirect_addr, instr_valid<=0 (flush, even if instr_ready=1), no capture, stay in FETCH.
  2. Slot free: capture. If code[22:20]==HALT_OP, go to HALTED. The HALT word is itself presented on instr and the pc still increments.
  3. Slot not free (instr_valid=1 and instr_ready=0): stall. instr, pc and fetch_count hold.
- HALTED:
  - halted=1. No capture.
  - The pending instr stays valid until handshaked, then instr_valid<=0.
  - redirect_valid=1: pc<=redirect_addr, instr_valid<=0, halted<=0, go to FETCH.
  - start is ignored in HALTED.
- Throughput: one instruction per cycle while instr_ready is held high.
- Latency: a word addressed in cycle N appears on instr with instr_valid=1 in cycle N+1.
- fetch_count wraps at 2^CNT_W without saturating.
- A redirect and a handshake in the same cycle: the redirect wins and the handshaked word is not recaptured.

Test Plan:
1. Reset, then start pulse at cycle 0, instr_ready=1 constant, memory contents addr0=23'h000000, addr1=23'h010001, addr2=23'h020002 -> cycle 2: instr=23'h000000, pc=1; cycle 3: instr=23'h010001; cycle 4: instr=23'h020002, pc=3, fetch_count=3.
2. Backpressure: while streaming, drop instr_ready for 3 cycles starting with instr=23'h010001 valid -> instr, pc=2 and fetch_count hold for 3 cycles; the cycle after instr_ready returns, instr=23'h020002.
3. Redirect: redirect_valid=1 with redirect_addr=6'h04 while instr_valid=1 -> next cycle instr_valid=0, pc=4; the following cycle instr=code at address 4 (23'h040004).
4. HALT: addr3=23'h700000, run from 0 -> instr=23'h700000 is presented, halted=1, pc=4, no further captures. After the handshake instr_valid=0. A redirect to 0 resumes fetching with halted=0.
5. Wrap: redirect to 6'h3F, then fetch -> instr=code at address 63, then pc=0 and the next instr=code at address 0.
6. Reset mid-stream with rst=1 for one cycle during a stall -> all outputs return to their reset values and the state returns to IDLE. No capture occurs until a new start pulse.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory address/data, the decode
// valid/ready handshake and the branch/jump redirect request.
interface fetch_unit_if #(
    parameter int ADDR_W = 6,
    parameter int CODE_W = 23
);
    logic [ADDR_W-1:0] address;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;

    // Fetch unit side
    modport master (
        output address,
        input  code,
        output instr,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_addr
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  address,
        output code,
        input  instr,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, reads the combinational
// instruction memory, holds one instruction for decode behind a valid/ready
// slot, and handles redirect, HALT and a wrapping fetch counter.
module fetch_unit #(
    parameter int         ADDR_W  = 6,
    parameter int         CODE_W  = 23,
    parameter logic [2:0] HALT_OP = 3'b111,
    parameter int         CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    fetch_unit_if.master      bus,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted,
    output logic [CNT_W-1:0]  o_fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [CODE_W-1:0] r_instr;
    logic              r_valid;
    logic              r_halted;
    logic [CNT_W-1:0]  r_count;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [CODE_W-1:0] w_instr_nxt;
    logic              w_valid_nxt;
    logic              w_halted_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_slot_free;
    logic              w_is_halt;
    logic              w_consumed;

    // The slot can take a new word when it is empty or being handed to decode.
    assign w_slot_free = ~r_valid | bus.instr_ready;
    assign w_consumed  = r_valid & bus.instr_ready;
    assign w_is_halt   = (bus.code[CODE_W-1 -: 3] == HALT_OP);

    assign bus.address     = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_valid;
    assign o_pc            = r_pc;
    assign o_halted        = r_halted;
    assign o_fetch_count   = r_count;

    // Next-state and datapath decisions; redirect always outranks capture.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_valid_nxt  = r_valid;
        w_halted_nxt = r_halted;
        w_count_nxt  = r_count;
        case (r_state)
            ST_IDLE: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt = bus.redirect_addr;
                end else if (i_start) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
                if (w_consumed) begin
                    w_valid_nxt = 1'b0;
                end else begin
                    w_valid_nxt = r_valid;
                end
            end
            ST_FETCH: begin
                if (bus.redirect_valid) begin
                    // Flush: the word in the slot is dropped even if handshaked.
                    w_pc_nxt    = bus.redirect_addr;
                    w_valid_nxt = 1'b0;
                end else if (w_slot_free) begin
                    w_instr_nxt = bus.code;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + ADDR_W'(1);
                    w_count_nxt = r_count + CNT_W'(1);
                    if (w_is_halt) begin
                        w_state_nxt  = ST_HALTED;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else begin
                    // Stall: decode has not taken the current word.
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt     = bus.redirect_addr;
                    w_valid_nxt  = 1'b0;
                    w_halted_nxt = 1'b0;
                    w_state_nxt  = ST_FETCH;
                end else if (w_consumed) begin
                    w_valid_nxt = 1'b0;
                end else begin
                    w_valid_nxt = r_valid;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_valid_nxt  = 1'b0;
                w_halted_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= {ADDR_W{1'b0}};
            r_instr  <= {CODE_W{1'b0}};
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_count  <= {CNT_W{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_valid  <= w_valid_nxt;
            r_halted <= w_halted_nxt;
            r_count  <= w_count_nxt;
        end
    end

endmodule
